// File: rtl/mcdf_pkg.sv
// Shared types and helpers for the MCDF round-robin arbiter.
package mcdf_pkg;

    localparam int unsigned PRIO_HIGHEST = 0;
    localparam int unsigned BEAT_CNT_W   = 8;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Channel-id width; never narrower than one bit.
    function automatic int unsigned ch_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational strict-priority selector with round-robin tie break after rr_ptr.
module rr_prio_select
    import mcdf_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned PRIO_W = 2,
    parameter int unsigned CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*PRIO_W-1:0] ch_prio,
    input  logic [CH_W-1:0]          rr_ptr,
    output logic [CH_W-1:0]          sel_c,
    output logic                     sel_vld_c
);

    logic [PRIO_W-1:0] prio_arr [NUM_CH];
    logic [PRIO_W-1:0] min_prio;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            prio_arr[i] = ch_prio[i*PRIO_W +: PRIO_W];
        end
    end

    // Lowest priority value among requesting channels
    always_comb begin
        min_prio = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_valid[i] && (prio_arr[i] < min_prio)) begin
                min_prio = prio_arr[i];
            end
        end
    end

    // Scan starting just after rr_ptr, wrapping, for the first channel at min_prio
    always_comb begin
        int unsigned idx;
        logic        found;
        idx       = 0;
        found     = 1'b0;
        sel_c     = '0;
        sel_vld_c = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = 32'(rr_ptr) + 32'(k);
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && ch_valid[CH_W'(idx)] && (prio_arr[CH_W'(idx)] == min_prio)) begin
                sel_c = CH_W'(idx);
                found = 1'b1;
            end
        end
        sel_vld_c = found;
    end

endmodule

// File: rtl/mcdf_arbiter_rr.sv
// N-channel priority/round-robin arbiter with optional burst lock and a registered
// valid/ready output stage feeding the MCDF formatter.
module mcdf_arbiter_rr
    import mcdf_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PRIO_W    = 2,
    parameter int unsigned BURST_LEN = 1,
    localparam int unsigned CH_W     = ch_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arb_en,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic [NUM_CH*PRIO_W-1:0] ch_prio,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic [DATA_W-1:0]        out_data
);

    localparam int unsigned     CNT_W     = BEAT_CNT_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [CH_W-1:0]  RR_RST    = CH_W'(NUM_CH - 1);

    arb_state_t        state, state_nxt;
    logic [CH_W-1:0]   lock_ch, lock_ch_nxt;
    logic [CH_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;

    logic [CH_W-1:0]   arb_sel_c;
    logic              arb_vld_c;
    logic [CH_W-1:0]   sel_c;
    logic              sel_vld_c;
    logic              lock_hold_c;
    logic              out_free_c;
    logic              load_c;
    logic [DATA_W-1:0] sel_data_c;

    rr_prio_select #(
        .NUM_CH (NUM_CH),
        .PRIO_W (PRIO_W),
        .CH_W   (CH_W)
    ) u_select (
        .ch_valid  (ch_valid),
        .ch_prio   (ch_prio),
        .rr_ptr    (rr_ptr),
        .sel_c     (arb_sel_c),
        .sel_vld_c (arb_vld_c)
    );

    // Grant source, load condition, one-hot ready and data mux
    always_comb begin
        lock_hold_c = (state == ARB_LOCKED) && ch_valid[lock_ch];
        sel_c       = lock_hold_c ? lock_ch : arb_sel_c;
        sel_vld_c   = lock_hold_c | arb_vld_c;
        out_free_c  = ~out_valid | out_ready;
        // Reset gates ready so no upstream beat is consumed and then dropped
        load_c      = rst_n & arb_en & sel_vld_c & out_free_c;
        ch_ready    = '0;
        sel_data_c  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == sel_c) begin
                ch_ready[i] = load_c;
                sel_data_c  = ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Burst-lock next state, beat counter and round-robin pointer
    always_comb begin
        state_nxt    = state;
        lock_ch_nxt  = lock_ch;
        beat_cnt_nxt = beat_cnt;
        rr_ptr_nxt   = rr_ptr;

        // Locked channel went idle while the output could take a beat: release the lock
        if (arb_en && out_free_c && (state == ARB_LOCKED) && !lock_hold_c) begin
            state_nxt    = ARB_IDLE;
            beat_cnt_nxt = '0;
        end

        if (load_c) begin
            rr_ptr_nxt = sel_c;
            if (lock_hold_c) begin
                if (beat_cnt == LAST_BEAT) begin
                    state_nxt    = ARB_IDLE;
                    beat_cnt_nxt = '0;
                end else begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end else if (BURST_LEN > 1) begin
                state_nxt    = ARB_LOCKED;
                lock_ch_nxt  = sel_c;
                beat_cnt_nxt = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            lock_ch  <= '0;
            beat_cnt <= '0;
            rr_ptr   <= RR_RST;
        end else begin
            state    <= state_nxt;
            lock_ch  <= lock_ch_nxt;
            beat_cnt <= beat_cnt_nxt;
            rr_ptr   <= rr_ptr_nxt;
        end
    end

    // Output register: load on accept, otherwise hold until drained by out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load_c) begin
            out_valid <= 1'b1;
            out_data  <= sel_data_c;
            out_ch    <= sel_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
